// File: rtl/bus_address_router_pkg.sv
// Shared types and default address map for the single-master request router.
package bus_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_RESP = 2'd2,
    ST_RESPOND   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RESP_OK         = 2'b00,
    RESP_TARGET_ERR = 2'b01,
    RESP_DECODE_ERR = 2'b10,
    RESP_TIMEOUT    = 2'b11
  } resp_status_e;

  localparam int DEFAULT_N_TARGETS = 4;

  // Index 0 sits in the LSBs.
  localparam logic [127:0] DEFAULT_BASE_ADDRESSES =
    {32'h43c03000, 32'h43c02000, 32'h43c01000, 32'h43c00000};

  localparam logic [31:0] DEFAULT_WINDOW_SIZE = 32'h1000;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_address_router_if.sv
// Upstream request/response bus between the bus root and the router.
interface bus_address_router_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic [1:0]            resp_status;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_status
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_status
  );
endinterface

// File: rtl/bus_address_router_decoder.sv
// Combinational address decode: per-target window hit, lowest-index priority
// select, offset relative to the selected base, and miss flag.
module bus_address_decoder
  import bus_router_pkg::*;
#(
  parameter int                            N_TARGETS      = DEFAULT_N_TARGETS,
  parameter int                            ADDR_WIDTH     = 32,
  parameter int                            SEL_WIDTH      = 2,
  parameter logic [N_TARGETS*ADDR_WIDTH-1:0] BASE_ADDRESSES = DEFAULT_BASE_ADDRESSES,
  parameter logic [ADDR_WIDTH-1:0]         WINDOW_SIZE    = DEFAULT_WINDOW_SIZE
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [SEL_WIDTH-1:0]  sel,
  output logic [ADDR_WIDTH-1:0] offset,
  output logic                  miss
);

  logic [N_TARGETS-1:0] hit;

  // One extra bit so a window ending at the top of the address space never wraps.
  always_comb begin
    hit = '0;
    for (int i = 0; i < N_TARGETS; i++) begin
      hit[i] = ({1'b0, addr} >= {1'b0, BASE_ADDRESSES[i*ADDR_WIDTH +: ADDR_WIDTH]}) &&
               ({1'b0, addr} <  ({1'b0, BASE_ADDRESSES[i*ADDR_WIDTH +: ADDR_WIDTH]} +
                                 {1'b0, WINDOW_SIZE}));
    end
  end

  always_comb begin
    sel    = '0;
    offset = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel    = SEL_WIDTH'(i);
        offset = addr - BASE_ADDRESSES[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign miss = ~|hit;

endmodule

// File: rtl/bus_address_router.sv
// Sequential single-master to N-target request router with decode, timeout
// and sticky stuck-target tracking; one transaction outstanding at a time.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | ready for a new request, decode and capture on req_valid
// ISSUE     | t_req_valid[sel] asserted, waiting for target handshake
// WAIT_RESP | t_resp_ready[sel] asserted, waiting for target response
// RESPOND   | resp_valid held with data/status until upstream accepts
module bus_address_router
  import bus_router_pkg::*;
#(
  parameter int                              N_TARGETS      = DEFAULT_N_TARGETS,
  parameter int                              ADDR_WIDTH     = 32,
  parameter int                              DATA_WIDTH     = 32,
  parameter logic [N_TARGETS*ADDR_WIDTH-1:0] BASE_ADDRESSES = DEFAULT_BASE_ADDRESSES,
  parameter logic [ADDR_WIDTH-1:0]           WINDOW_SIZE    = DEFAULT_WINDOW_SIZE,
  parameter int                              TIMEOUT_CYCLES = 256
) (
  input  logic                            clock,
  input  logic                            reset,
  bus_address_router_if.slave             bus,
  output logic [N_TARGETS-1:0]            t_req_valid,
  input  logic [N_TARGETS-1:0]            t_req_ready,
  output logic                            t_req_write,
  output logic [ADDR_WIDTH-1:0]           t_req_addr,
  output logic [DATA_WIDTH-1:0]           t_req_wdata,
  input  logic [N_TARGETS-1:0]            t_resp_valid,
  output logic [N_TARGETS-1:0]            t_resp_ready,
  input  logic [N_TARGETS*DATA_WIDTH-1:0] t_resp_rdata,
  input  logic [N_TARGETS-1:0]            t_resp_err,
  input  logic                            clear_stuck,
  output logic [N_TARGETS-1:0]            stuck_flags,
  output logic                            busy
);

  localparam int SEL_W = sel_width(N_TARGETS);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE      = ST_IDLE;
  localparam logic [1:0] ISSUE     = ST_ISSUE;
  localparam logic [1:0] WAIT_RESP = ST_WAIT_RESP;
  localparam logic [1:0] RESPOND   = ST_RESPOND;

  logic [1:0]            state;
  logic [SEL_W-1:0]      sel_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            status_q;
  logic [CNT_W-1:0]      cnt;

  logic [SEL_W-1:0]      dec_sel;
  logic [ADDR_WIDTH-1:0] dec_offset;
  logic                  dec_miss;
  logic [N_TARGETS-1:0]  sel_onehot;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  timeout_hit;

  bus_address_decoder #(
    .N_TARGETS      (N_TARGETS),
    .ADDR_WIDTH     (ADDR_WIDTH),
    .SEL_WIDTH      (SEL_W),
    .BASE_ADDRESSES (BASE_ADDRESSES),
    .WINDOW_SIZE    (WINDOW_SIZE)
  ) u_decoder (
    .addr   (bus.req_addr),
    .sel    (dec_sel),
    .offset (dec_offset),
    .miss   (dec_miss)
  );

  assign sel_onehot  = N_TARGETS'(1) << sel_q;
  assign sel_rdata   = t_resp_rdata[sel_q*DATA_WIDTH +: DATA_WIDTH];
  // >= rather than == so a handshake on the last budget cycle still times out
  // in WAIT_RESP instead of letting the counter wrap.
  assign timeout_hit = (cnt >= CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      status_q    <= RESP_OK;
      cnt         <= '0;
      stuck_flags <= '0;
    end else begin
      if (clear_stuck) stuck_flags <= '0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.req_valid) begin
            sel_q   <= dec_sel;
            write_q <= bus.req_write;
            addr_q  <= dec_offset;
            wdata_q <= bus.req_wdata;
            rdata_q <= '0;
            if (dec_miss) begin
              status_q <= RESP_DECODE_ERR;
              state    <= RESPOND;
            end else if (stuck_flags[dec_sel]) begin
              status_q <= RESP_TIMEOUT;
              state    <= RESPOND;
            end else begin
              status_q <= RESP_OK;
              state    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt <= cnt + CNT_W'(1);
          if (t_req_ready[sel_q]) begin
            state <= WAIT_RESP;
          end else if (timeout_hit) begin
            stuck_flags[sel_q] <= 1'b1;
            status_q           <= RESP_TIMEOUT;
            state              <= RESPOND;
          end
        end
        WAIT_RESP: begin
          cnt <= cnt + CNT_W'(1);
          if (t_resp_valid[sel_q]) begin
            status_q <= t_resp_err[sel_q] ? RESP_TARGET_ERR : RESP_OK;
            rdata_q  <= (write_q || t_resp_err[sel_q]) ? '0 : sel_rdata;
            state    <= RESPOND;
          end else if (timeout_hit) begin
            stuck_flags[sel_q] <= 1'b1;
            status_q           <= RESP_TIMEOUT;
            state              <= RESPOND;
          end
        end
        RESPOND: begin
          if (bus.resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = (state == IDLE);
  assign bus.resp_valid  = (state == RESPOND);
  assign bus.resp_rdata  = (state == RESPOND) ? rdata_q : '0;
  assign bus.resp_status = (state == RESPOND) ? status_q : 2'b00;

  assign t_req_valid  = (state == ISSUE) ? sel_onehot : '0;
  // Stuck targets keep their response channel open so late responses drain.
  assign t_resp_ready = ((state == WAIT_RESP) ? sel_onehot : '0) | stuck_flags;
  assign t_req_write  = write_q;
  assign t_req_addr   = addr_q;
  assign t_req_wdata  = wdata_q;
  assign busy         = (state != IDLE);

endmodule

// File: doc/bus_address_router.md
Name: bus_address_router

Overview:
- Parametrised successor to the fixed address-map package: a sequential single-master to N-target request router.
- Decodes each request address against per-target base/window parameters and forwards it, offset-relative, to the selected target.
- Returns the target response, or an error status on decode miss, target timeout or stuck target.
- Sits between the bus root and the crossbar/module leaves; one transaction outstanding at a time.

Parameters:
N_TARGETS, 4, number of downstream targets (1..16)
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, data width
BASE_ADDRESSES, {32'h43c03000,32'h43c02000,32'h43c01000,32'h43c00000}, packed array [N_TARGETS][ADDR_WIDTH], index 0 in LSBs
WINDOW_SIZE, 32'h1000, byte span of every target window
TIMEOUT_CYCLES, 256, cycles allowed in ISSUE+WAIT_RESP before timeout (>=2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  1  upstream request valid
req_ready  out  1  upstream request accepted
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  absolute address
req_wdata  in  DATA_WIDTH  write data
resp_valid  out  1  upstream response valid
resp_ready  in  1  upstream response accepted
resp_rdata  out  DATA_WIDTH  read data (0 on error or write)
resp_status  out  2  00 OK, 01 TARGET_ERR, 10 DECODE_ERR, 11 TIMEOUT
t_req_valid  out  N_TARGETS  one-hot target request valid
t_req_ready  in  N_TARGETS  target request ready
t_req_write  out  1  shared write flag
t_req_addr  out  ADDR_WIDTH  shared offset address (req_addr - BASE[sel])
t_req_wdata  out  DATA_WIDTH  shared write data
t_resp_valid  in  N_TARGETS  target response valid
t_resp_ready  out  N_TARGETS  target response ready
t_resp_rdata  in  N_TARGETS*DATA_WIDTH  target read data, flattened
t_resp_err  in  N_TARGETS  target error flag
clear_stuck  in  1  pulse: clear all stuck flags
stuck_flags  out  N_TARGETS  sticky per-target timeout flags
busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high): state IDLE.
  - All outputs 0 except req_ready=1.
  - stuck_flags=0, timeout counter=0, captured request registers=0.
- Decode (combinational on req_addr):
  - hit[i] = req_addr >= BASE[i] && req_addr < BASE[i]+WINDOW_SIZE, computed at ADDR_WIDTH+1 bits so the window end never wraps.
  - Overlapping windows: the lowest index wins.
- IDLE:
  - req_ready=1. On req_valid, capture write/offset/wdata/sel.
  - Next state:
    - no hit -> RESPOND with DECODE_ERR
    - hit on a stuck target -> RESPOND with TIMEOUT
    - otherwise -> ISSUE
  - Timeout counter cleared.
- ISSUE:
  - t_req_valid[sel]=1; t_req_* held stable.
  - On t_req_ready[sel] -> WAIT_RESP.
- WAIT_RESP:
  - t_resp_ready[sel]=1.
  - On t_resp_valid[sel], latch rdata (0 for writes) and status (TARGET_ERR if t_resp_err[sel], else OK) -> RESPOND.
- RESPOND:
  - resp_valid=1 with data/status stable until resp_ready -> IDLE.
  - req_ready=0 in every state except IDLE.
- Timeout:
  - Counter increments each cycle in ISSUE and WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completion: set stuck_flags[sel], go to RESPOND with TIMEOUT, deassert t_req_valid.
  - Completion and timeout in the same cycle: completion wins.
- Stuck targets:
  - t_resp_ready[i]=1 permanently while stuck_flags[i]=1, so late responses are drained and discarded.
  - clear_stuck clears all flags next cycle; a timeout on that same cycle sets its bit, and the set wins.
- Latency: request accept to t_req_valid is 1 cycle; target response to resp_valid is 1 cycle; a decode miss reaches resp_valid 1 cycle after accept.
- Only t_req_valid[sel] may assert, one-hot or zero.

Decomposition:
- Package bus_router_pkg:
  - state enum (IDLE, ISSUE, WAIT_RESP, RESPOND)
  - resp_status enum (OK, TARGET_ERR, DECODE_ERR, TIMEOUT)
  - default BASE_ADDRESSES/WINDOW constants
- Sub-module bus_address_decoder: combinational hit vector, priority select index, offset, miss flag.

Test Plan:
- Read 0x43C01004, target1 returns 0xDEADBEEF after 3 cycles -> t_req_addr=0x004, t_req_valid=4'b0010, resp_valid with rdata 0xDEADBEEF, status 00.
- Write 0x43C05000 -> no t_req_valid, resp_valid one cycle after accept, status 10, rdata 0.
- TIMEOUT_CYCLES=16, target2 never ready on 0x43C02010 -> resp status 11 exactly 16 cycles after ISSUE entry, stuck_flags=4'b0100; the next access to target2 gets immediate status 11.
- Target2 late response while stuck -> drained via t_resp_ready[2]=1, no upstream resp_valid; clear_stuck -> flags 0, a normal read then succeeds.
- Target3 responds with t_resp_err=1, upstream holds resp_ready=0 for 5 cycles -> resp_valid, rdata and status 01 held stable, req_ready=0 throughout.
- Reset asserted mid-WAIT_RESP -> state IDLE, t_req_valid=0, resp_valid=0, stuck_flags=0, req_ready=1 asynchronously.
